// File: rtl/clk_freq_meter_if.sv
// Control/result bundle for the clock frequency meter.
// Master issues start/sel/gate_cycles; slave returns status and result.
interface clk_freq_meter_if #(
  parameter int N_CLOCKS = 4,
  parameter int GATE_W   = 16,
  parameter int COUNT_W  = 20
);
  localparam int SEL_W = (N_CLOCKS > 1) ? $clog2(N_CLOCKS) : 1;

  logic               start;
  logic [SEL_W-1:0]   sel;
  logic [GATE_W-1:0]  gate_cycles;
  logic               busy;
  logic               done;
  logic [COUNT_W-1:0] result;
  logic               overflow;

  modport master (
    output start, sel, gate_cycles,
    input  busy, done, result, overflow
  );

  modport slave (
    input  start, sel, gate_cycles,
    output busy, done, result, overflow
  );
endinterface

// File: rtl/clk_freq_meter.sv
// Counts rising edges of a selected test clock over a window of
// reference cycles, using per-channel Gray counters crossed into ref.
module clk_freq_meter #(
  parameter int N_CLOCKS = 4,
  parameter int GATE_W   = 16,
  parameter int COUNT_W  = 20,
  parameter int GRAY_W   = 4
) (
  input  logic                padin_clk_rooted,
  input  logic                rst_n_padin_clk,
  input  logic [N_CLOCKS-1:0] clk_test,
  clk_freq_meter_if.slave     bus
);
  localparam int SEL_W = (N_CLOCKS > 1) ? $clog2(N_CLOCKS) : 1;
  localparam int N_SEL = 2 ** SEL_W;
  localparam int SUM_W = COUNT_W + 1;

  typedef enum logic {S_IDLE, S_COUNT} state_t;

  function automatic logic [GRAY_W-1:0] g2b(
    input logic [GRAY_W-1:0] g
  );
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GRAY_W-1:0] b2g(
    input logic [GRAY_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  logic [GRAY_W-1:0] w_delta [N_SEL];

  for (genvar g = 0; g < N_CLOCKS; g++) begin : g_ch
    logic [1:0]        r_rst_sync;
    logic [GRAY_W-1:0] r_gray;
    logic [GRAY_W-1:0] r_gs1;
    logic [GRAY_W-1:0] r_gs2;
    logic [GRAY_W-1:0] r_prev;
    logic [GRAY_W-1:0] w_bin;

    always_ff @(posedge clk_test[g] or negedge rst_n_padin_clk) begin
      if (!rst_n_padin_clk) r_rst_sync <= '0;
      else                  r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    always_ff @(posedge clk_test[g] or negedge r_rst_sync[1]) begin
      if (!r_rst_sync[1]) r_gray <= '0;
      else                r_gray <= b2g(g2b(r_gray) + GRAY_W'(1));
    end

    // Only Gray-coded state crosses; one bit changes per test edge.
    always_ff @(posedge padin_clk_rooted or negedge rst_n_padin_clk) begin
      if (!rst_n_padin_clk) begin
        r_gs1  <= '0;
        r_gs2  <= '0;
        r_prev <= '0;
      end else begin
        r_gs1  <= r_gray;
        r_gs2  <= r_gs1;
        r_prev <= w_bin;
      end
    end

    assign w_bin      = g2b(r_gs2);
    assign w_delta[g] = w_bin - r_prev;
  end

  for (genvar g = N_CLOCKS; g < N_SEL; g++) begin : g_pad
    assign w_delta[g] = '0;
  end

  state_t             r_state;
  state_t             w_next;
  logic [SEL_W-1:0]   r_sel_q;
  logic [GATE_W-1:0]  r_ctr;
  logic [COUNT_W-1:0] r_acc;
  logic               r_sat;
  logic [COUNT_W-1:0] r_result;
  logic               r_overflow;
  logic               r_done;
  logic               w_busy;
  logic               w_start_ok;
  logic               w_last;
  logic [SUM_W-1:0]   w_sum;
  logic               w_carry;
  logic [COUNT_W-1:0] w_acc_n;

  assign w_start_ok = (r_state == S_IDLE) && bus.start;
  assign w_last     = (r_state == S_COUNT) && (r_ctr == GATE_W'(1));
  assign w_sum      = {1'b0, r_acc} + SUM_W'(w_delta[r_sel_q]);
  assign w_carry    = w_sum[COUNT_W];
  assign w_acc_n    = w_carry ? '1 : w_sum[COUNT_W-1:0];

  always_ff @(posedge padin_clk_rooted or negedge rst_n_padin_clk) begin
    if (!rst_n_padin_clk) r_state <= S_IDLE;
    else                  r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      w_start_ok: w_next = S_COUNT;
      w_last:     w_next = S_IDLE;
      default:    ;
    endcase
  end

  always_comb begin
    w_busy = (r_state == S_COUNT);
  end

  always_ff @(posedge padin_clk_rooted or negedge rst_n_padin_clk) begin
    if (!rst_n_padin_clk) begin
      r_sel_q    <= '0;
      r_ctr      <= '0;
      r_acc      <= '0;
      r_sat      <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_start_ok) begin
        r_sel_q    <= bus.sel;
        r_ctr      <= (bus.gate_cycles == '0) ? GATE_W'(1)
                                              : bus.gate_cycles;
        r_acc      <= '0;
        r_sat      <= 1'b0;
        r_overflow <= 1'b0;
      end else if (r_state == S_COUNT) begin
        r_acc <= w_acc_n;
        r_sat <= r_sat | w_carry;
        r_ctr <= r_ctr - GATE_W'(1);
        if (w_last) begin
          r_result   <= w_acc_n;
          r_overflow <= r_sat | w_carry;
        end
      end
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.overflow = r_overflow;
endmodule
